// File: rtl/ad9228_tx_gearbox.sv
// 12-to-8 transmit gearbox: packs sample words MSB-first into a contiguous byte stream.
// Optional AD9228_TX_FCO_GEN_EN adds an fco_out byte lane carrying the frame-clock pattern.
module ad9228_tx_gearbox #(
  parameter int DATA_WIDTH = 12,
  parameter int BYTE_WIDTH = 8
) (
  input  logic                  data_in_clk,
  input  logic                  rstn,
  input  logic [DATA_WIDTH-1:0] word_in,
  input  logic                  word_valid,
  output logic                  word_ready,
  output logic [BYTE_WIDTH-1:0] byte_out,
  output logic                  byte_valid,
  output logic                  underrun,
  input  logic                  underrun_clr
`ifdef AD9228_TX_FCO_GEN_EN
  ,
  output logic [BYTE_WIDTH-1:0] fco_out
`endif
);

  localparam int BUF_W = DATA_WIDTH + BYTE_WIDTH;
  localparam int CNT_W = $clog2(BUF_W + 1);
  localparam logic [CNT_W-1:0] BYTE_CNT = CNT_W'(BYTE_WIDTH);
  localparam logic [CNT_W-1:0] WORD_CNT = CNT_W'(DATA_WIDTH);

  typedef enum logic {
    IDLE,
    STREAM
  } state_e;

  state_e                 state_q, state_d;
  logic [BUF_W-1:0]       buf_q, buf_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic [BYTE_WIDTH-1:0]  byte_q, byte_d;
  logic                   byte_valid_q, byte_valid_d;
  logic                   underrun_q, underrun_d;

  logic                   emit;
  logic                   accept;
  logic [CNT_W-1:0]       rem;
  logic [BUF_W-1:0]       word_ext;

  // Word placed left-aligned; shifting right by rem lands it just below the held bits.
  assign word_ext = {word_in, {BYTE_WIDTH{1'b0}}};

  always_comb begin
    emit         = (count_q >= BYTE_CNT);
    rem          = emit ? (count_q - BYTE_CNT) : count_q;
    word_ready   = (rem <= BYTE_CNT);
    accept       = word_valid & word_ready;

    buf_d        = emit ? (buf_q << BYTE_WIDTH) : buf_q;
    if (accept) begin
      buf_d      = buf_d | (word_ext >> rem);
    end
    count_d      = rem + (accept ? WORD_CNT : '0);

    state_d      = state_q;
    if (accept) begin
      state_d    = STREAM;
    end

    underrun_d   = ((state_q == STREAM) && !emit) || (underrun_q && !underrun_clr);
    byte_d       = emit ? buf_q[BUF_W-1 -: BYTE_WIDTH] : '0;
    byte_valid_d = emit;
  end

  always_ff @(posedge data_in_clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= IDLE;
      buf_q        <= '0;
      count_q      <= '0;
      byte_q       <= '0;
      byte_valid_q <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      buf_q        <= buf_d;
      count_q      <= count_d;
      byte_q       <= byte_d;
      byte_valid_q <= byte_valid_d;
      underrun_q   <= underrun_d;
    end
  end

  assign byte_out   = byte_q;
  assign byte_valid = byte_valid_q;
  assign underrun   = underrun_q;

`ifdef AD9228_TX_FCO_GEN_EN
  // Tag lane mirrors buf exactly, so each fco byte lines up with its data byte.
  localparam logic [DATA_WIDTH-1:0] FCO_TAG =
    {{(DATA_WIDTH/2){1'b1}}, {(DATA_WIDTH/2){1'b0}}};

  logic [BUF_W-1:0]      tag_q, tag_d;
  logic [BYTE_WIDTH-1:0] fco_q, fco_d;
  logic [BUF_W-1:0]      tag_ext;

  assign tag_ext = {FCO_TAG, {BYTE_WIDTH{1'b0}}};

  always_comb begin
    tag_d = emit ? (tag_q << BYTE_WIDTH) : tag_q;
    if (accept) begin
      tag_d = tag_d | (tag_ext >> rem);
    end
    fco_d = emit ? tag_q[BUF_W-1 -: BYTE_WIDTH] : '0;
  end

  always_ff @(posedge data_in_clk or negedge rstn) begin
    if (!rstn) begin
      tag_q <= '0;
      fco_q <= '0;
    end else begin
      tag_q <= tag_d;
      fco_q <= fco_d;
    end
  end

  assign fco_out = fco_q;
`endif

endmodule

// File: tb/tb_ad9228_tx_gearbox.sv
// Self-checking bench for ad9228_tx_gearbox: directed cycle table plus stream/reset sequences.
module tb_ad9228_tx_gearbox;

  logic        data_in_clk = 1'b0;
  logic        rstn = 1'b0;
  logic [11:0] word_in = '0;
  logic        word_valid = 1'b0;
  logic        underrun_clr = 1'b0;
  logic        word_ready;
  logic [7:0]  byte_out;
  logic        byte_valid;
  logic        underrun;
`ifdef AD9228_TX_FCO_GEN_EN
  logic [7:0]  fco_out;
`endif

  int checks = 0;
  int errors = 0;

  ad9228_tx_gearbox #(
    .DATA_WIDTH(12),
    .BYTE_WIDTH(8)
  ) dut (
    .data_in_clk (data_in_clk),
    .rstn        (rstn),
    .word_in     (word_in),
    .word_valid  (word_valid),
    .word_ready  (word_ready),
    .byte_out    (byte_out),
    .byte_valid  (byte_valid),
    .underrun    (underrun),
    .underrun_clr(underrun_clr)
`ifdef AD9228_TX_FCO_GEN_EN
    ,
    .fco_out     (fco_out)
`endif
  );

  always #5 data_in_clk = ~data_in_clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge data_in_clk);
    rstn         = 1'b0;
    word_valid   = 1'b0;
    word_in      = '0;
    underrun_clr = 1'b0;
    repeat (2) @(negedge data_in_clk);
    rstn = 1'b1;
  endtask

  typedef struct {
    logic        valid;
    logic [11:0] word;
    logic        clr;
    logic        exp_ready;
    logic        exp_bv;
    logic [7:0]  exp_byte;
    logic        exp_ur;
  } vec_t;

  vec_t vt[17];

  task automatic run_stream(input string tag, input int n, input bit throttle);
    logic [11:0] words[$];
    logic [7:0]  exp_b[$];
    logic [7:0]  got[$];
    logic [7:0]  gotf[$];
    logic [15:0] lfsr = 16'hACE1;
    logic [11:0] a, b;
    int idx = 0, cyc = 0, budget = n * 4 + 50;
    int ready_bad = 0, gap_bad = 0, ur_bad = 0, byte_bad = 0, extra_bad = 0;
    words.push_back(12'hABC);
    words.push_back(12'hDEF);
    for (int i = 2; i < n; i++) words.push_back(12'($urandom));
    for (int i = 0; i < n; i += 2) begin
      a = words[i];
      b = words[i+1];
      exp_b.push_back(a[11:4]);
      exp_b.push_back({a[3:0], b[11:8]});
      exp_b.push_back(b[7:0]);
    end
    while ((idx < n || got.size() < exp_b.size()) && cyc < budget) begin
      @(negedge data_in_clk);
      if (byte_valid) begin
        got.push_back(byte_out);
`ifdef AD9228_TX_FCO_GEN_EN
        gotf.push_back(fco_out);
`endif
      end else if (!throttle && idx < n && got.size() > 0) begin
        gap_bad++;
      end
      if (!throttle && idx < n && underrun) ur_bad++;
      lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      word_valid = (idx < n) && (!throttle || lfsr[0]);
      word_in    = (idx < n) ? words[idx] : '0;
      #1;
      if (!throttle && idx < n && word_ready !== ((cyc < 3) || (cyc % 3 != 0))) ready_bad++;
      if (word_valid && word_ready) idx++;
      cyc++;
    end
    word_valid = 1'b0;
    word_in    = '0;
    repeat (3) begin
      @(negedge data_in_clk);
      if (byte_valid !== 1'b0) extra_bad++;
    end
    chk({tag, "_completed"}, 32'(idx == n && got.size() == exp_b.size()), 32'd1);
    for (int i = 0; i < got.size() && i < exp_b.size(); i++)
      if (got[i] !== exp_b[i]) byte_bad++;
    chk({tag, "_byte_mismatches"}, 32'(byte_bad), 32'd0);
    chk({tag, "_extra_bytes"}, 32'(extra_bad), 32'd0);
    if (!throttle) begin
      chk({tag, "_first_byte"}, 32'(got.size() > 0 ? got[0] : 8'h00), 32'h0AB);
      chk({tag, "_ready_pattern_errs"}, 32'(ready_bad), 32'd0);
      chk({tag, "_gap_cycles"}, 32'(gap_bad), 32'd0);
      chk({tag, "_underrun_cycles"}, 32'(ur_bad), 32'd0);
    end
`ifdef AD9228_TX_FCO_GEN_EN
    begin
      int fco_bad = 0;
      logic [7:0] ef;
      for (int i = 0; i < gotf.size(); i++) begin
        case (i % 3)
          0:       ef = 8'hFC;
          1:       ef = 8'h0F;
          default: ef = 8'hC0;
        endcase
        if (gotf[i] !== ef) fco_bad++;
      end
      chk({tag, "_fco_count"}, 32'(gotf.size()), 32'(exp_b.size()));
      chk({tag, "_fco_mismatches"}, 32'(fco_bad), 32'd0);
    end
`endif
  endtask

  initial begin
    //          valid word     clr  rdy  bv   byte   ur
    vt[0]  = '{1'b1, 12'hABC, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0};
    vt[1]  = '{1'b0, 12'h000, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0};
    vt[2]  = '{1'b0, 12'h000, 1'b0, 1'b1, 1'b1, 8'hAB, 1'b0};
    vt[3]  = '{1'b0, 12'h000, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1};
    vt[4]  = '{1'b1, 12'hDEF, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1};
    vt[5]  = '{1'b0, 12'h000, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1};
    vt[6]  = '{1'b0, 12'h000, 1'b0, 1'b1, 1'b1, 8'hCD, 1'b0};
    vt[7]  = '{1'b0, 12'h000, 1'b0, 1'b1, 1'b1, 8'hEF, 1'b0};
    vt[8]  = '{1'b1, 12'h111, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1};
    vt[9]  = '{1'b1, 12'h222, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1};
    vt[10] = '{1'b1, 12'h333, 1'b0, 1'b1, 1'b1, 8'h11, 1'b1};
    vt[11] = '{1'b1, 12'h444, 1'b0, 1'b0, 1'b1, 8'h12, 1'b1};
    vt[12] = '{1'b1, 12'h444, 1'b0, 1'b1, 1'b1, 8'h22, 1'b1};
    vt[13] = '{1'b0, 12'h000, 1'b0, 1'b1, 1'b1, 8'h33, 1'b1};
    vt[14] = '{1'b0, 12'h000, 1'b0, 1'b1, 1'b1, 8'h34, 1'b1};
    vt[15] = '{1'b0, 12'h000, 1'b0, 1'b1, 1'b1, 8'h44, 1'b1};
    vt[16] = '{1'b0, 12'h000, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1};

    do_reset();
    #1;
    chk("reset_byte_out", 32'(byte_out), 32'd0);
    chk("reset_byte_valid", 32'(byte_valid), 32'd0);
    chk("reset_underrun", 32'(underrun), 32'd0);
    chk("reset_word_ready", 32'(word_ready), 32'd1);
`ifdef AD9228_TX_FCO_GEN_EN
    chk("reset_fco_out", 32'(fco_out), 32'd0);
`endif

    for (int i = 0; i < 17; i++) begin
      @(negedge data_in_clk);
      word_valid   = vt[i].valid;
      word_in      = vt[i].word;
      underrun_clr = vt[i].clr;
      #1;
      chk($sformatf("vec%0d_word_ready", i), 32'(word_ready), 32'(vt[i].exp_ready));
      chk($sformatf("vec%0d_byte_valid", i), 32'(byte_valid), 32'(vt[i].exp_bv));
      chk($sformatf("vec%0d_byte_out", i), 32'(byte_out), 32'(vt[i].exp_byte));
      chk($sformatf("vec%0d_underrun", i), 32'(underrun), 32'(vt[i].exp_ur));
    end
    word_valid   = 1'b0;
    underrun_clr = 1'b0;

    do_reset();
    run_stream("cont", 300, 1'b0);

    do_reset();
    run_stream("thr", 100, 1'b1);
    chk("thr_underrun_set", 32'(underrun), 32'd1);
    @(negedge data_in_clk);
    underrun_clr = 1'b1;
    @(negedge data_in_clk);
    underrun_clr = 1'b0;
    chk("thr_clr_vs_set_set_wins", 32'(underrun), 32'd1);

    // Async reset while count is 16 and a byte is on the output.
    do_reset();
    @(negedge data_in_clk);
    word_valid = 1'b1;
    word_in    = 12'hABC;
    @(negedge data_in_clk);
    word_in    = 12'hDEF;
    @(negedge data_in_clk);
    word_valid = 1'b0;
    word_in    = '0;
    #1;
    chk("mid_pre_reset_byte", 32'(byte_out), 32'h0AB);
    rstn = 1'b0;
    #1;
    chk("mid_reset_byte_out", 32'(byte_out), 32'd0);
    chk("mid_reset_byte_valid", 32'(byte_valid), 32'd0);
    chk("mid_reset_underrun", 32'(underrun), 32'd0);
    chk("mid_reset_word_ready", 32'(word_ready), 32'd1);
`ifdef AD9228_TX_FCO_GEN_EN
    chk("mid_reset_fco_out", 32'(fco_out), 32'd0);
`endif
    @(negedge data_in_clk);
    rstn = 1'b1;
    @(negedge data_in_clk);
    word_valid = 1'b1;
    word_in    = 12'h123;
    for (int k = 1; k <= 5; k++) begin
      @(negedge data_in_clk);
      word_valid = 1'b0;
      word_in    = '0;
      #1;
      chk($sformatf("post_reset_c%0d_byte_valid", k), 32'(byte_valid), 32'(k == 2));
      chk($sformatf("post_reset_c%0d_byte_out", k), 32'(byte_out), (k == 2) ? 32'h12 : 32'h0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
